// File: rtl/spi_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tx_pkg
//  Description : Shared types and constants for the counter SPI transmitter.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_tx_pkg;

    // Frame length matches the width of the upstream 0-9999 counter output
    localparam int FRAME_BITS = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_tx_state_e;

endpackage
`default_nettype wire

// File: rtl/count_spi_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : count_spi_tx_if
//  Description : Request/status handshake plus SPI pins of the transmitter.
//  Revision    : 1.0  initial release
// ============================================================================
interface count_spi_tx_if
    import spi_tx_pkg::*;
#(
    parameter int DATA_W = FRAME_BITS
) ();

    logic [DATA_W-1:0] count_in;
    logic              tx_start;
    logic              busy;
    logic              done;
    logic              sclk;
    logic              mosi;
    logic              cs_n;

    // Requesting side: supplies the value and the start strobe
    modport master (
        output count_in,
        output tx_start,
        input  busy,
        input  done,
        input  sclk,
        input  mosi,
        input  cs_n
    );

    // Transmitter side
    modport slave (
        input  count_in,
        input  tx_start,
        output busy,
        output done,
        output sclk,
        output mosi,
        output cs_n
    );

endinterface
`default_nettype wire

// File: rtl/spi_half_timer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_half_timer
//  Description : CLK_DIV-cycle down-counter with load/enable; pulses o_expire
//                on the last cycle of every CLK_DIV-cycle phase.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_half_timer #(
    parameter int CLK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_load,
    input  wire logic i_en,
    output logic      o_expire
);

    localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] c_RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Down-count while enabled; reload on expiry so phases run back to back
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_RELOAD;
        end else if (i_en) begin
            if (r_cnt == '0) begin
                r_cnt <= c_RELOAD;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_expire = i_en && !i_load && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/count_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : count_spi_tx
//  Description : SPI mode-0 transmit-only master that sends one DATA_W-bit
//                counter value per frame, MSB first, with a guaranteed
//                chip-select-high gap between frames.
//  Revision    : 1.0  initial release
// ============================================================================
module count_spi_tx
    import spi_tx_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = FRAME_BITS
) (
    input  wire logic     clk,
    input  wire logic     reset,
    count_spi_tx_if.slave bus
);

    localparam int               BIT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(DATA_W - 1);

    spi_tx_state_e     r_state;
    spi_tx_state_e     w_state_nxt;

    logic              w_accept;
    logic              w_timer_en;
    logic              w_expire;

    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [BIT_W-1:0]  w_bit_cnt_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic              r_sclk;
    logic              w_sclk_nxt;
    logic              r_mosi;
    logic              w_mosi_nxt;
    logic              r_cs_n;
    logic              w_cs_n_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_busy;

    assign w_accept   = (r_state == IDLE) && bus.tx_start;
    assign w_timer_en = (r_state != IDLE);

    // One timer paces SETUP, every SCLK half-period, HOLD and GAP
    spi_half_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_half_timer (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_accept),
        .i_en     (w_timer_en),
        .o_expire (w_expire)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; SHIFT ends after the low phase following the last falling edge
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (bus.tx_start)                   w_state_nxt = SETUP;
            SETUP:   if (w_expire)                       w_state_nxt = SHIFT;
            SHIFT:   if (w_expire && !r_sclk && r_last)  w_state_nxt = HOLD;
            HOLD:    if (w_expire)                       w_state_nxt = GAP;
            GAP:     if (w_expire)                       w_state_nxt = IDLE;
            default:                                     w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_last_nxt    = r_last;
        w_sclk_nxt    = r_sclk;
        w_mosi_nxt    = r_mosi;
        w_cs_n_nxt    = r_cs_n;
        w_done_nxt    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.tx_start) begin
                    w_shift_nxt   = bus.count_in;
                    w_mosi_nxt    = bus.count_in[DATA_W-1];
                    w_cs_n_nxt    = 1'b0;
                    w_bit_cnt_nxt = '0;
                    w_last_nxt    = 1'b0;
                end
            end
            SETUP: begin
                if (w_expire) begin
                    w_sclk_nxt = 1'b1;
                end
            end
            SHIFT: begin
                if (w_expire) begin
                    if (r_sclk) begin
                        // Falling edge: present the next bit and count it
                        w_sclk_nxt  = 1'b0;
                        w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
                        w_mosi_nxt  = r_shift[DATA_W-2];
                        if (r_bit_cnt == c_BIT_LAST) begin
                            w_bit_cnt_nxt = '0;
                            w_last_nxt    = 1'b1;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        end
                    end else if (!r_last) begin
                        w_sclk_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (w_expire) begin
                    w_cs_n_nxt = 1'b1;
                    w_mosi_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                    w_last_nxt = 1'b0;
                end
            end
            GAP: begin
                w_done_nxt = 1'b0;
            end
            default: begin
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; reset aborts any frame without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_last    <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_last    <= w_last_nxt;
            r_sclk    <= w_sclk_nxt;
            r_mosi    <= w_mosi_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

    assign bus.sclk = r_sclk;
    assign bus.mosi = r_mosi;
    assign bus.cs_n = r_cs_n;
    assign bus.done = r_done;
    assign bus.busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_count_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_spi_tx
//  Description : Self-checking bench for count_spi_tx (CLK_DIV=4 and 2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_count_spi_tx;

    logic clk;
    logic reset;

    count_spi_tx_if #(.DATA_W(16)) if4 ();
    count_spi_tx_if #(.DATA_W(16)) if2 ();

    count_spi_tx #(.CLK_DIV(4), .DATA_W(16)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4)
    );

    count_spi_tx #(.CLK_DIV(2), .DATA_W(16)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0] exp_q[$];

    // Monitor view: sel picks which DUT is being observed
    bit   sel = 1'b0;
    int   cd  = 4;
    logic m_sclk, m_mosi, m_cs_n, m_busy, m_done;
    assign m_sclk = sel ? if2.sclk : if4.sclk;
    assign m_mosi = sel ? if2.mosi : if4.mosi;
    assign m_cs_n = sel ? if2.cs_n : if4.cs_n;
    assign m_busy = sel ? if2.busy : if4.busy;
    assign m_done = sel ? if2.done : if4.done;

    bit          mon_en   = 1'b0;
    bit          aborting = 1'b0;
    int          cyc = 0, cs_low = 0, rise_cnt = 0, n_cs_fall = 0, n_done = 0;
    int          last_rise_cyc = 0, done_cyc = 0, cs_rise_cyc = 0, last_gap = 0;
    logic [15:0] shreg = '0;
    logic        p_sclk = 1'b0, p_cs_n = 1'b1, p_busy = 1'b0, p_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Sample the SPI pins mid-cycle, rebuild each frame and check it against the queue
    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (mon_en) begin
                if (!m_cs_n && p_cs_n) begin
                    n_cs_fall++;
                    cs_low   = 0;
                    rise_cnt = 0;
                    shreg    = '0;
                    last_gap = cyc - cs_rise_cyc;
                end
                if (!m_cs_n) cs_low++;
                if (m_sclk && !p_sclk) begin
                    if (rise_cnt == 0) chk("first_rise_delay", cs_low, cd + 1);
                    else               chk("sclk_period", cyc - last_rise_cyc, 2 * cd);
                    chk("rise_inside_cs", m_cs_n, 1'b0);
                    last_rise_cyc = cyc;
                    rise_cnt++;
                    shreg = {shreg[14:0], m_mosi};
                end
                if (m_done) begin
                    n_done++;
                    done_cyc = cyc;
                    chk("done_width", p_done, 1'b0);
                end
                if (m_cs_n && !p_cs_n) begin
                    cs_rise_cyc = cyc;
                    if (aborting) begin
                        chk("abort_no_done", m_done, 1'b0);
                    end else begin
                        chk("done_at_cs_rise", m_done, 1'b1);
                        chk("rise_count", rise_cnt, 16);
                        chk("cs_low_len", cs_low, 34 * cd);
                        if (exp_q.size() == 0) chk("sb_underflow", 0, 1);
                        else                   chk("frame_data", shreg, exp_q.pop_front());
                    end
                end
                if (!m_busy && p_busy) begin
                    if (!aborting) chk("busy_after_done", cyc - done_cyc, cd);
                    aborting = 1'b0;
                end
                p_sclk = m_sclk;
                p_cs_n = m_cs_n;
                p_busy = m_busy;
                p_done = m_done;
            end
        end
    end

    task automatic start4(input logic [15:0] v, input bit push);
        tick();
        if4.count_in = v;
        if4.tx_start = 1'b1;
        if (push) exp_q.push_back(v);
        tick();
        if4.tx_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int k = 0;
        while (n_done < target && k < 3000) begin
            tick();
            k++;
        end
        if (n_done < target) chk(tag, n_done, target);
    endtask

    task automatic wait_rise(input int n, input string tag);
        int k = 0;
        while (rise_cnt < n && k < 3000) begin
            tick();
            k++;
        end
        chk(tag, rise_cnt, n);
    endtask

    task automatic wait_fall(input int target, input string tag);
        int k = 0;
        while (n_cs_fall < target && k < 3000) begin
            tick();
            k++;
        end
        if (n_cs_fall < target) chk(tag, n_cs_fall, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bd, bf;
        clk   = 1'b0;
        reset = 1'b1;
        if4.tx_start = 1'b0; if4.count_in = '0;
        if2.tx_start = 1'b0; if2.count_in = '0;
        repeat (3) tick();

        // Reset state of both instances
        chk("rst_cs_n", {if4.cs_n, if2.cs_n}, 2'b11);
        chk("rst_sclk", {if4.sclk, if2.sclk}, 2'b00);
        chk("rst_mosi", {if4.mosi, if2.mosi}, 2'b00);
        chk("rst_busy", {if4.busy, if2.busy}, 2'b00);
        chk("rst_done", {if4.done, if2.done}, 2'b00);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        // 1: single frame of 9999
        bd = n_done;
        start4(16'h270F, 1'b1);
        chk("t1_busy", if4.busy, 1'b1);
        wait_done(bd + 1, "t1_timeout");
        repeat (10) tick();
        chk("t1_done_cnt", n_done - bd, 1);
        chk("t1_idle", if4.busy, 1'b0);

        // 2: back-to-back frames with tx_start held high
        bd = n_done;
        bf = n_cs_fall;
        tick();
        if4.count_in = 16'h0000;
        if4.tx_start = 1'b1;
        exp_q.push_back(16'h0000);
        tick();
        if4.count_in = 16'hFFFF;
        exp_q.push_back(16'hFFFF);
        wait_fall(bf + 2, "t2_fall_timeout");
        if4.tx_start = 1'b0;
        chk("t2_cs_gap", last_gap, cd + 1);
        wait_done(bd + 2, "t2_timeout");
        repeat (60) tick();
        chk("t2_frames", n_cs_fall - bf, 2);
        chk("t2_done_cnt", n_done - bd, 2);

        // 3: tx_start pulses during a frame are ignored
        bd = n_done;
        bf = n_cs_fall;
        start4(16'h1234, 1'b1);
        wait_rise(3, "t3_rise3");
        if4.tx_start = 1'b1; tick(); if4.tx_start = 1'b0;
        wait_rise(10, "t3_rise10");
        if4.tx_start = 1'b1; tick(); if4.tx_start = 1'b0;
        wait_done(bd + 1, "t3_timeout");
        repeat (60) tick();
        chk("t3_frames", n_cs_fall - bf, 1);
        chk("t3_done_cnt", n_done - bd, 1);

        // 4: count_in changes right after the start is accepted
        bd = n_done;
        start4(16'h0005, 1'b1);
        if4.count_in = 16'h0006;
        wait_done(bd + 1, "t4_timeout");
        repeat (10) tick();

        // 5: reset at the 8th rising edge aborts the frame
        bd = n_done;
        start4(16'hA5C3, 1'b0);
        wait_rise(8, "t5_rise8");
        aborting = 1'b1;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        chk("t5_cs_n", if4.cs_n, 1'b1);
        chk("t5_sclk", if4.sclk, 1'b0);
        chk("t5_mosi", if4.mosi, 1'b0);
        chk("t5_busy", if4.busy, 1'b0);
        repeat (200) tick();
        chk("t5_no_done", n_done - bd, 0);
        start4(16'h3C5A, 1'b1);
        wait_done(bd + 1, "t5_timeout");
        repeat (10) tick();

        // 6: CLK_DIV=2 instance
        sel = 1'b1;
        cd  = 2;
        bd  = n_done;
        tick();
        if2.count_in = 16'h8001;
        if2.tx_start = 1'b1;
        exp_q.push_back(16'h8001);
        tick();
        if2.tx_start = 1'b0;
        wait_done(bd + 1, "t6_timeout");
        repeat (10) tick();
        chk("t6_done_cnt", n_done - bd, 1);

        chk("sb_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
